sort_stream_ctrl: RTL
=====================

Name: sort_stream_ctrl

Overview:
- Stream front/back end for the in-place RAM sorter.
- Accepts a packet on an Avalon-ST sink and writes it into the shared dual-port RAM through its own port.
- Hands the RAM to the sorter with a one-cycle start pulse and the last address, then waits for the sorter to finish.
- Reads the sorted words back out on an Avalon-ST source with sop/eop framing.

Parameters:
DWIDTH, 8, data word width
MAX_PKT_LEN, 16, RAM depth and maximum packet length in words; power of two, at least 2
AWIDTH, $clog2(MAX_PKT_LEN), address width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
snk_data_i  in  DWIDTH  input word
snk_startofpacket_i  in  1  first word of packet
snk_endofpacket_i  in  1  last word of packet
snk_valid_i  in  1  input word valid
snk_ready_o  out  1  block accepts input
src_data_o  out  DWIDTH  sorted output word
src_startofpacket_o  out  1  first output word
src_endofpacket_o  out  1  last output word
src_valid_o  out  1  output word valid
src_ready_i  in  1  downstream accepts output
ram_addr_o  out  AWIDTH  RAM address, own port
ram_data_o  out  DWIDTH  RAM write data
ram_we_o  out  1  RAM write enable
ram_q_i  in  DWIDTH  RAM read data, 2-cycle registered latency
ram_owner_sort_o  out  1  1 = top-level mux gives both RAM ports to the sorter
last_addr_o  out  AWIDTH  index of last stored word, to the sorter
start_sorting_o  out  1  one-cycle start pulse to the sorter
end_sorting_i  in  1  sorter idle/done (high when idle)

Behaviour:
- Reset: asynchronous on rst_n_i low, affects all state.
  - State = LOAD, write pointer = 0, last_addr_o = 0.
  - All outputs 0 except snk_ready_o = 1.
  - Reset mid-packet, mid-sort or mid-unload aborts everything. RAM contents are don't-care.
- State LOAD:
  - snk_ready_o = 1. A word transfers when snk_valid_i & snk_ready_o.
  - Words before the first sop are dropped.
  - On sop: write the word to address 0 and set the pointer to 1.
  - Each subsequent word writes to the pointer address, then the pointer increments.
  - A sop arriving mid-packet restarts the packet at address 0.
  - Write is combinational: ram_we_o = transfer, ram_addr_o = pointer, ram_data_o = snk_data_i.
- End of packet (eop, or sop&eop together):
  - last_addr_o is registered with the word's address.
  - If last_addr_o = 0, go to UNLOAD (no sort). Otherwise go to START.
- Overflow: if a packet reaches MAX_PKT_LEN words without eop, word MAX_PKT_LEN-1 is treated as eop. Later words are dropped (ready stays low from then on).
- State START (1 cycle):
  - snk_ready_o = 0, start_sorting_o = 1, ram_owner_sort_o = 1. Then go to SORT.
- State SORT:
  - ram_owner_sort_o = 1, own ram_we_o = 0.
  - end_sorting_i is ignored for the first 2 cycles after the start pulse (sorter done flag lags).
  - From the 3rd cycle on, end_sorting_i = 1 moves the block to UNLOAD and clears ram_owner_sort_o.
- State UNLOAD (stop-and-wait, per word k = 0..last_addr_o):
  - Drive ram_addr_o = k, wait 2 cycles, capture ram_q_i.
  - Assert src_valid_o with the captured data.
  - src_startofpacket_o = (k == 0). src_endofpacket_o = (k == last_addr_o).
  - Hold data and flags stable while src_ready_i = 0.
  - On handshake, drop src_valid_o and issue read k+1. Throughput is 1 word per 3 cycles with src_ready_i held high.
  - After the eop handshake, go to LOAD with the pointer at 0.
- snk_ready_o = 0 in every state except LOAD. The block never asserts snk_ready_o and src_valid_o in the same cycle.
- ram_we_o is never asserted outside LOAD.

Test Plan:
- Reset check: hold rst_n_i low for 3 cycles mid-stream → all outputs 0 and snk_ready_o = 1. The next packet is processed normally.
- Basic sort: send 4-word packet [3,9,1,7] (sop on 3, eop on 7), src_ready_i = 1, sorter model active.
  - Required: last_addr_o = 3, one start_sorting_o pulse, start ignored end_sorting_i for 2 cycles.
  - Required output: words 9,7,3,1 with sop on 9 and eop on 1.
- Single word: send [5] with sop&eop together → no start_sorting_o pulse, output 5 with sop&eop, return to LOAD.
- Framing errors:
  - 2 words without sop, then [4,2] → output [4,2] sorted descending.
  - A sop mid-packet [8,6,sop 1,eop 2] → only [1,2] is sorted, output [2,1].
- Overflow: 20 words with no eop, MAX_PKT_LEN = 16 → last_addr_o = 15, 16 words sorted, words 17..20 dropped.
- Backpressure: src_ready_i toggles 0/1 every 2 cycles during UNLOAD → src_data_o and flags stable while stalled, no word lost or duplicated.

Source files
------------

// File: rtl/sort_stream_ctrl.sv
// Stream front/back end for the in-place RAM sorter.
// It loads one Avalon-ST packet into the shared RAM and passes the RAM to the
// sorter with a start pulse. When the sorter reports done, it reads the words
// back out as a framed Avalon-ST packet, one word at a time.
module sort_stream_ctrl #(
   parameter  int DWIDTH      = 8,
   parameter  int MAX_PKT_LEN = 16,
   localparam int AWIDTH      = $clog2(MAX_PKT_LEN)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DWIDTH-1:0] snk_data_i,
   input  logic              snk_startofpacket_i,
   input  logic              snk_endofpacket_i,
   input  logic              snk_valid_i,
   output logic              snk_ready_o,
   output logic [DWIDTH-1:0] src_data_o,
   output logic              src_startofpacket_o,
   output logic              src_endofpacket_o,
   output logic              src_valid_o,
   input  logic              src_ready_i,
   output logic [AWIDTH-1:0] ram_addr_o,
   output logic [DWIDTH-1:0] ram_data_o,
   output logic              ram_we_o,
   input  logic [DWIDTH-1:0] ram_q_i,
   output logic              ram_owner_sort_o,
   output logic [AWIDTH-1:0] last_addr_o,
   output logic              start_sorting_o,
   input  logic              end_sorting_i
);

   localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(MAX_PKT_LEN - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_START,
      S_SORT,
      S_UNLOAD
   } state_e;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic              in_pkt_q, in_pkt_d;
   logic [AWIDTH-1:0] last_addr_q, last_addr_d;
   logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;
   logic [1:0]        sort_cnt_q, sort_cnt_d;
   logic [DWIDTH-1:0] src_data_q, src_data_d;
   logic              src_sop_q, src_sop_d;
   logic              src_eop_q, src_eop_d;
   logic              src_valid_q, src_valid_d;
   logic              snk_ready_q, snk_ready_d;
   logic              start_q, start_d;
   logic              owner_q, owner_d;

   logic              accept;
   logic              wr_en;
   logic [AWIDTH-1:0] wr_addr;
   logic              pkt_end;
   logic              src_hs;
   logic [AWIDTH-1:0] rd_addr;

   // Sink transfer decode, write address and read-address look-ahead.
   always_comb begin
      accept  = snk_valid_i & snk_ready_q;
      // Words seen outside a packet (before any sop) are accepted and discarded.
      wr_en   = accept & (snk_startofpacket_i | in_pkt_q);
      // A sop always restarts the packet at address 0, even mid-packet.
      wr_addr = snk_startofpacket_i ? '0 : wr_ptr_q;
      // The last RAM slot closes the packet even without eop.
      pkt_end = wr_en & (snk_endofpacket_i | (wr_addr == LAST_IDX));
      src_hs  = src_valid_q & src_ready_i;
      // The next read is issued in the same cycle as the handshake so that a
      // continuously ready sink sees one word every three cycles.
      rd_addr = src_hs ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   // Next-state and next-output computation for the load/sort/unload sequence.
   always_comb begin
      // NOTE: every signal gets a default first so that no path through the
      // case statement leaves a value unassigned and infers a latch.
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      in_pkt_d    = in_pkt_q;
      last_addr_d = last_addr_q;
      rd_ptr_d    = rd_ptr_q;
      wait_cnt_d  = wait_cnt_q;
      sort_cnt_d  = sort_cnt_q;
      src_data_d  = src_data_q;
      src_sop_d   = src_sop_q;
      src_eop_d   = src_eop_q;
      src_valid_d = src_valid_q;

      unique case (state_q)
         S_LOAD: begin
            if (wr_en) begin
               wr_ptr_d = wr_addr + 1'b1;
               in_pkt_d = 1'b1;
            end
            if (pkt_end) begin
               last_addr_d = wr_addr;
               wr_ptr_d    = '0;
               in_pkt_d    = 1'b0;
               if (wr_addr == '0) begin
                  // A one-word packet is already sorted.
                  state_d    = S_UNLOAD;
                  rd_ptr_d   = '0;
                  wait_cnt_d = '0;
               end else begin
                  state_d = S_START;
               end
            end
         end

         S_START: begin
            state_d    = S_SORT;
            sort_cnt_d = '0;
         end

         S_SORT: begin
            // The sorter's done flag is still high from the previous run for
            // two cycles after the start pulse, so it is not trusted yet.
            if (sort_cnt_q != 2'd2) begin
               sort_cnt_d = sort_cnt_q + 2'd1;
            end else if (end_sorting_i) begin
               state_d    = S_UNLOAD;
               rd_ptr_d   = '0;
               wait_cnt_d = '0;
            end
         end

         S_UNLOAD: begin
            if (!src_valid_q) begin
               if (wait_cnt_q == 2'd2) begin
                  src_valid_d = 1'b1;
                  src_data_d  = ram_q_i;
                  src_sop_d   = (rd_ptr_q == '0);
                  src_eop_d   = (rd_ptr_q == last_addr_q);
               end else begin
                  wait_cnt_d = wait_cnt_q + 2'd1;
               end
            end else if (src_ready_i) begin
               src_valid_d = 1'b0;
               src_sop_d   = 1'b0;
               src_eop_d   = 1'b0;
               if (src_eop_q) begin
                  state_d  = S_LOAD;
                  rd_ptr_d = '0;
               end else begin
                  // The read of k+1 went out during the handshake cycle.
                  rd_ptr_d   = rd_ptr_q + 1'b1;
                  wait_cnt_d = 2'd1;
               end
            end
         end

         default: state_d = S_LOAD;
      endcase

      // Control outputs are registered from the state being entered.
      snk_ready_d = (state_d == S_LOAD);
      start_d     = (state_d == S_START);
      owner_d     = (state_d == S_START) || (state_d == S_SORT);
   end

   // State and registered outputs; reset aborts any packet in progress.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_LOAD;
         wr_ptr_q    <= '0;
         in_pkt_q    <= 1'b0;
         last_addr_q <= '0;
         rd_ptr_q    <= '0;
         wait_cnt_q  <= '0;
         sort_cnt_q  <= '0;
         src_data_q  <= '0;
         src_sop_q   <= 1'b0;
         src_eop_q   <= 1'b0;
         src_valid_q <= 1'b0;
         snk_ready_q <= 1'b1;
         start_q     <= 1'b0;
         owner_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // values computed in the previous cycle, independent of order.
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         in_pkt_q    <= in_pkt_d;
         last_addr_q <= last_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         wait_cnt_q  <= wait_cnt_d;
         sort_cnt_q  <= sort_cnt_d;
         src_data_q  <= src_data_d;
         src_sop_q   <= src_sop_d;
         src_eop_q   <= src_eop_d;
         src_valid_q <= src_valid_d;
         snk_ready_q <= snk_ready_d;
         start_q     <= start_d;
         owner_q     <= owner_d;
      end
   end

   // RAM port: combinational write path while loading, read address while
   // unloading, parked at 0 while the sorter owns the RAM.
   always_comb begin
      ram_we_o   = wr_en;
      ram_data_o = wr_en ? snk_data_i : '0;
      unique case (state_q)
         S_LOAD:   ram_addr_o = wr_addr;
         S_UNLOAD: ram_addr_o = rd_addr;
         default:  ram_addr_o = '0;
      endcase
   end

   assign snk_ready_o         = snk_ready_q;
   assign src_data_o          = src_data_q;
   assign src_startofpacket_o = src_sop_q;
   assign src_endofpacket_o   = src_eop_q;
   assign src_valid_o         = src_valid_q;
   assign ram_owner_sort_o    = owner_q;
   assign last_addr_o         = last_addr_q;
   assign start_sorting_o     = start_q;

endmodule
